my_alu: RTL and testbench



---
 rtl/my_alu_pkg.sv | 34 +++
 rtl/alu_addsub.sv | 23 ++
 rtl/my_alu.sv | 166 ++++++++++++++++
 tb/tb_my_alu.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/my_alu_pkg.sv
// Shared definitions for the 1801VM1 ALU: operation indices, flag positions
// and the signed boundary values used by the overflow rules.
package my_alu_pkg;

  localparam int unsigned NUM_OPS = 24;

  // Strobe indices; lower index wins when several strobes are asserted.
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_ADC  = 5'd1,  OP_SUB  = 5'd2,  OP_SBC  = 5'd3,
    OP_INC2 = 5'd4,  OP_DEC2 = 5'd5,  OP_INC  = 5'd6,  OP_DEC  = 5'd7,
    OP_CLR  = 5'd8,  OP_COM  = 5'd9,  OP_NEG  = 5'd10, OP_TST  = 5'd11,
    OP_ROR  = 5'd12, OP_ROL  = 5'd13, OP_ASR  = 5'd14, OP_ASL  = 5'd15,
    OP_SXT  = 5'd16, OP_MOV  = 5'd17, OP_CMP  = 5'd18, OP_BIT  = 5'd19,
    OP_BIC  = 5'd20, OP_BIS  = 5'd21, OP_EXOR = 5'd22, OP_SWAB = 5'd23,
    OP_NONE = 5'd24
  } op_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  localparam logic [15:0] WORD_MAX_POS = 16'o077777;
  localparam logic [15:0] WORD_MIN_NEG = 16'o100000;
  localparam logic [7:0]  BYTE_MAX_POS = 8'o177;
  localparam logic [7:0]  BYTE_MIN_NEG = 8'o200;

  // Operations that always work on full words regardless of mbyte.
  function automatic logic ignores_mbyte(op_e op);
    return op inside {OP_ADD, OP_SUB, OP_INC2, OP_DEC2, OP_SXT, OP_EXOR,
                      OP_SWAB, OP_NONE};
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// 16-bit adder with carry-in; carry and overflow taps at the byte and word msb.
module alu_addsub (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        c8,
  output logic        v8,
  output logic        c16,
  output logic        v16
);

  logic [16:0] full;

  assign full = {1'b0, a} + {1'b0, b} + 17'(cin);
  assign sum  = full[15:0];
  assign c16  = full[16];
  // Carry into bit k is recovered as a[k]^b[k]^sum[k].
  assign c8   = a[8] ^ b[8] ^ sum[8];
  assign v8   = (a[7] ^ b[7] ^ sum[7]) ^ c8;
  assign v16  = (a[15] ^ b[15] ^ sum[15]) ^ c16;

endmodule

// File: rtl/my_alu.sv
// Combinational PDP-11/1801VM1 ALU with a one-cycle registered copy of
// result and flags for status capture.
module my_alu
  import my_alu_pkg::*;
(
  input  logic        clkdbi,
  input  logic        reset_n,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        ni,
  input  logic        ci,
  input  logic        mbyte,
  input  logic        add, adc, sub, sbc, inc2, dec2, inc, dec,
  input  logic        clr, com, neg, tst, ror, rol, asr, asl,
  input  logic        sxt, mov, cmp, bit_, bic, bis, exor, swab,
  output logic [15:0] final_result,
  output logic [3:0]  final_flags,
  output logic [3:0]  ccmask,
  output logic [15:0] result_q,
  output logic [3:0]  flags_q
);

  logic [NUM_OPS-1:0] strb;
  op_e                op;
  logic               bm;
  logic [15:0]        add_a, add_b, sum;
  logic               add_cin, c8, v8, c16, v16, ar_c, ar_v;
  logic [15:0]        res;
  logic [3:0]         mask, flags;
  logic               v_raw, c_raw, v_shift, nz_low, n, z, v;

  assign strb = {swab, exor, bis, bic, bit_, cmp, mov, sxt, asl, asr, rol, ror,
                 tst, neg, com, clr, dec, inc, dec2, inc2, sbc, sub, adc, add};

  always_comb begin
    op = OP_NONE;
    for (int i = NUM_OPS - 1; i >= 0; i--)
      if (strb[i]) op = op_e'(5'(i));
  end

  assign bm = mbyte & ~ignores_mbyte(op);

  // Operand steering: subtraction is D + ~S + 1, borrow is the inverted carry.
  always_comb begin
    add_a   = in2;
    add_b   = 16'h0000;
    add_cin = 1'b0;
    case (op)
      OP_ADD:  add_b = in1;
      OP_ADC:  add_cin = ci;
      OP_SUB:  begin add_b = ~in1; add_cin = 1'b1; end
      OP_SBC:  begin add_b = 16'hFFFF; add_cin = ~ci; end
      OP_CMP:  begin add_a = in1; add_b = ~in2; add_cin = 1'b1; end
      OP_INC:  add_cin = 1'b1;
      OP_DEC:  add_b = 16'hFFFF;
      OP_INC2: add_b = 16'h0002;
      OP_DEC2: add_b = 16'hFFFE;
      OP_NEG:  begin add_a = ~in2; add_cin = 1'b1; end
      default: ;
    endcase
  end

  alu_addsub u_alu_addsub (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (sum),
    .c8  (c8),
    .v8  (v8),
    .c16 (c16),
    .v16 (v16)
  );

  assign ar_c = bm ? c8 : c16;
  assign ar_v = bm ? v8 : v16;

  always_comb begin
    res     = 16'h0000;
    mask    = 4'b0000;
    v_raw   = 1'b0;
    c_raw   = 1'b0;
    v_shift = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin res = sum; mask = 4'b1111; v_raw = ar_v; c_raw = ar_c; end
      OP_SUB, OP_SBC, OP_CMP: begin
        res = sum; mask = 4'b1111; v_raw = ar_v; c_raw = ~ar_c;
      end
      OP_INC: begin
        res = sum; mask = 4'b1110;
        v_raw = bm ? (in2[7:0] == BYTE_MAX_POS) : (in2 == WORD_MAX_POS);
      end
      OP_DEC: begin
        res = sum; mask = 4'b1110;
        v_raw = bm ? (in2[7:0] == BYTE_MIN_NEG) : (in2 == WORD_MIN_NEG);
      end
      OP_INC2, OP_DEC2: res = sum;
      OP_CLR: mask = 4'b1111;
      OP_COM: begin res = ~in2; mask = 4'b1111; c_raw = 1'b1; end
      OP_NEG: begin
        res = sum; mask = 4'b1111;
        v_raw = bm ? (sum[7:0] == BYTE_MIN_NEG) : (sum == WORD_MIN_NEG);
        c_raw = bm ? |sum[7:0] : |sum;
      end
      OP_TST: begin res = in2; mask = 4'b1111; end
      OP_ROR: begin
        res = bm ? {8'h00, ci, in2[7:1]} : {ci, in2[15:1]};
        mask = 4'b1111; c_raw = in2[0]; v_shift = 1'b1;
      end
      OP_ROL: begin
        res = bm ? {8'h00, in2[6:0], ci} : {in2[14:0], ci};
        mask = 4'b1111; c_raw = bm ? in2[7] : in2[15]; v_shift = 1'b1;
      end
      OP_ASR: begin
        res = bm ? {8'h00, in2[7], in2[7:1]} : {in2[15], in2[15:1]};
        mask = 4'b1111; c_raw = in2[0]; v_shift = 1'b1;
      end
      OP_ASL: begin
        res = bm ? {8'h00, in2[6:0], 1'b0} : {in2[14:0], 1'b0};
        mask = 4'b1111; c_raw = bm ? in2[7] : in2[15]; v_shift = 1'b1;
      end
      OP_SXT:  begin res = {16{ni}}; mask = 4'b0110; end
      OP_MOV:  begin res = in2; mask = 4'b1110; end
      OP_BIT:  begin res = in1 & in2; mask = 4'b1110; end
      OP_BIC:  begin res = ~in1 & in2; mask = 4'b1110; end
      OP_BIS:  begin res = in1 | in2; mask = 4'b1110; end
      OP_EXOR: begin res = in1 ^ in2; mask = 4'b1110; end
      OP_SWAB: begin res = {in2[7:0], in2[15:8]}; mask = 4'b1111; end
      default: ;
    endcase
  end

  // SWAB is a word op but reports N/Z on the new low byte.
  assign nz_low = bm | (op == OP_SWAB);
  assign n      = nz_low ? res[7] : res[15];
  assign z      = nz_low ? ~|res[7:0] : ~|res;
  assign v      = v_shift ? (n ^ c_raw) : v_raw;

  always_comb begin
    flags         = 4'b0000;
    flags[FLAG_N] = n;
    flags[FLAG_Z] = z;
    flags[FLAG_V] = v;
    flags[FLAG_C] = c_raw;
  end

  always_comb begin
    if (!bm)               final_result = res;
    else if (op == OP_MOV) final_result = {{8{res[7]}}, res[7:0]};
    else                   final_result = {in2[15:8], res[7:0]};
  end

  assign final_flags = flags & mask;
  assign ccmask      = mask;

  // Status capture register, loads every cycle.
  always_ff @(posedge clkdbi or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= 16'h0000;
      flags_q  <= 4'b0000;
    end else begin
      result_q <= final_result;
      flags_q  <= final_flags;
    end
  end

endmodule

// File: tb/tb_my_alu.sv
// Directed and randomized checks of my_alu against an arithmetic reference model.
module tb_my_alu;

  localparam int ADD = 0,  ADC = 1,  SUB = 2,  SBC = 3,  INC2 = 4,  DEC2 = 5;
  localparam int INC = 6,  DEC = 7,  CLR = 8,  COM = 9,  NEG = 10, TST = 11;
  localparam int ROR = 12, ROL = 13, ASR = 14, ASL = 15, SXT = 16, MOV = 17;
  localparam int CMP = 18, BIT = 19, BIC = 20, BIS = 21, EXOR = 22, SWAB = 23;

  logic        clkdbi = 1'b0;
  logic        reset_n;
  logic [15:0] in1, in2;
  logic        ni, ci, mbyte;
  logic [23:0] st;
  logic [15:0] final_result, result_q;
  logic [3:0]  final_flags, ccmask, flags_q;

  int checks = 0;
  int errors = 0;

  logic [15:0] bnd [0:8] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF,
                             16'h007F, 16'h0080, 16'h00FF, 16'hFF00};

  always #5 clkdbi = ~clkdbi;

  my_alu dut (
    .clkdbi(clkdbi), .reset_n(reset_n), .in1(in1), .in2(in2), .ni(ni), .ci(ci),
    .mbyte(mbyte),
    .add(st[ADD]), .adc(st[ADC]), .sub(st[SUB]), .sbc(st[SBC]),
    .inc2(st[INC2]), .dec2(st[DEC2]), .inc(st[INC]), .dec(st[DEC]),
    .clr(st[CLR]), .com(st[COM]), .neg(st[NEG]), .tst(st[TST]),
    .ror(st[ROR]), .rol(st[ROL]), .asr(st[ASR]), .asl(st[ASL]),
    .sxt(st[SXT]), .mov(st[MOV]), .cmp(st[CMP]), .bit_(st[BIT]),
    .bic(st[BIC]), .bis(st[BIS]), .exor(st[EXOR]), .swab(st[SWAB]),
    .final_result(final_result), .final_flags(final_flags), .ccmask(ccmask),
    .result_q(result_q), .flags_q(flags_q)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %o expected %o", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [23:0] s_vec, input logic [15:0] a, input logic [15:0] b,
                       input logic n_i, input logic c_i, input logic mb);
    st = s_vec; in1 = a; in2 = b; ni = n_i; ci = c_i; mbyte = mb;
    #1;
  endtask

  function automatic int sgn(input int x, input int w);
    return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
  endfunction

  function automatic bit ovf(input int t, input int w);
    return (t < -(1 << (w - 1))) || (t > (1 << (w - 1)) - 1);
  endfunction

  // Reference: {result, flags, mask} from plain integer arithmetic.
  function automatic logic [23:0] model(input logic [23:0] s_vec, input logic [15:0] s,
                                        input logic [15:0] d, input logic ni_v,
                                        input logic ci_v, input logic mb);
    int op, w, m, hb, sv, dv, sd, dd, r, res, cin;
    bit n, z, v, c, shiftv, lo;
    logic [3:0] mask, flags;
    op = 24;
    for (int i = 23; i >= 0; i--) if (s_vec[i]) op = i;
    if (op == 24) return 24'h0;
    w  = (mb && !(op inside {ADD, SUB, INC2, DEC2, SXT, EXOR, SWAB})) ? 8 : 16;
    m  = (1 << w) - 1;
    hb = 1 << (w - 1);
    sv = int'(s) & m;  dv = int'(d) & m;
    sd = sgn(sv, w);   dd = sgn(dv, w);
    cin = ci_v ? 1 : 0;
    v = 0; c = 0; shiftv = 0; lo = 0; mask = 4'b1111; r = 0;
    case (op)
      ADD:  begin r = dv + sv;  c = (r > m); v = ovf(dd + sd, w); end
      ADC:  begin r = dv + cin; c = (r > m); v = ovf(dd + cin, w); end
      SUB:  begin r = dv - sv;  c = (r < 0); v = ovf(dd - sd, w); end
      SBC:  begin r = dv - cin; c = (r < 0); v = ovf(dd - cin, w); end
      CMP:  begin r = sv - dv;  c = (r < 0); v = ovf(sd - dd, w); end
      INC:  begin r = dv + 1; mask = 4'b1110; v = ovf(dd + 1, w); end
      DEC:  begin r = dv - 1; mask = 4'b1110; v = ovf(dd - 1, w); end
      INC2: begin r = dv + 2; mask = 4'b0000; end
      DEC2: begin r = dv - 2; mask = 4'b0000; end
      CLR:  r = 0;
      COM:  begin r = ~dv; c = 1; end
      NEG:  begin r = -dv; v = ((r & m) == hb); c = ((r & m) != 0); end
      TST:  r = dv;
      ROR:  begin r = (cin * hb) + (dv / 2); c = dv[0]; shiftv = 1; end
      ROL:  begin r = dv * 2 + cin; c = (dv & hb) != 0; shiftv = 1; end
      ASR:  begin r = (dv / 2) | (dv & hb); c = dv[0]; shiftv = 1; end
      ASL:  begin r = dv * 2; c = (dv & hb) != 0; shiftv = 1; end
      SXT:  begin r = ni_v ? 65535 : 0; mask = 4'b0110; end
      MOV:  begin r = dv; mask = 4'b1110; end
      BIT:  begin r = sv & dv; mask = 4'b1110; end
      BIC:  begin r = ~sv & dv; mask = 4'b1110; end
      BIS:  begin r = sv | dv; mask = 4'b1110; end
      EXOR: begin r = sv ^ dv; mask = 4'b1110; end
      SWAB: begin r = (dv % 256) * 256 + dv / 256; lo = 1; end
      default: ;
    endcase
    r = r & m;
    if (lo) begin n = ((r / 128) % 2) == 1; z = (r % 256) == 0; end
    else    begin n = (r / hb) == 1;        z = (r == 0); end
    if (shiftv) v = n ^ c;
    if (w == 8) res = (op == MOV) ? ((r >= 128) ? r + 65280 : r) : ((int'(d) & 65280) | r);
    else        res = r;
    flags = {n, z, v, c} & mask;
    return {16'(res), flags, mask};
  endfunction

  function automatic logic [15:0] pick();
    if ($urandom_range(0, 2) == 0) return bnd[$urandom_range(0, 8)];
    return 16'($urandom);
  endfunction

  logic [23:0] e, sv_r;
  int          first;

  initial begin
    reset_n = 1'b0;
    drive(24'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset result_q", result_q, 16'h0);
    check("reset flags_q", 16'(flags_q), 16'h0);
    @(negedge clkdbi) reset_n = 1'b1;

    @(negedge clkdbi);
    drive(24'd1 << ADD, 16'o000001, 16'o077777, 1'b0, 1'b0, 1'b0);
    check("add result", final_result, 16'o100000);
    check("add flags", 16'(final_flags), 16'b1010);
    check("add mask", 16'(ccmask), 16'b1111);
    drive(24'd1 << SUB, 16'o000001, 16'o000000, 1'b0, 1'b0, 1'b0);
    check("sub result", final_result, 16'o177777);
    check("sub flags", 16'(final_flags), 16'b1001);
    drive(24'd1 << CMP, 16'o000001, 16'o000000, 1'b0, 1'b0, 1'b0);
    check("cmp result", final_result, 16'o000001);
    check("cmp flags", 16'(final_flags), 16'b0000);
    drive(24'd1 << INC, 16'o0, 16'o000177, 1'b0, 1'b0, 1'b1);
    check("incb result", final_result, 16'o000200);
    check("incb flags", 16'(final_flags), 16'b1010);
    check("incb mask", 16'(ccmask), 16'b1110);
    drive(24'd1 << MOV, 16'o0, 16'o000200, 1'b0, 1'b0, 1'b1);
    check("movb result", final_result, 16'o177600);
    check("movb flags", 16'(final_flags), 16'b1000);
    drive(24'd1 << ROR, 16'o0, 16'o000001, 1'b0, 1'b1, 1'b0);
    check("ror result", final_result, 16'o100000);
    check("ror flags", 16'(final_flags), 16'b1001);
    drive(24'd1 << SWAB, 16'o0, 16'o000400, 1'b0, 1'b0, 1'b0);
    check("swab result", final_result, 16'o000001);
    check("swab flags", 16'(final_flags), 16'b0000);
    drive(24'd1 << SXT, 16'o0, 16'o0, 1'b1, 1'b0, 1'b0);
    check("sxt result", final_result, 16'o177777);
    check("sxt mask", 16'(ccmask), 16'b0110);
    check("sxt flags", 16'(final_flags), 16'b0000);
    drive(24'd1 << DEC2, 16'o0, 16'o001000, 1'b0, 1'b0, 1'b0);
    check("dec2 result", final_result, 16'o000776);
    check("dec2 mask", 16'(ccmask), 16'b0000);
    drive((24'd1 << ADD) | (24'd1 << SWAB), 16'd1, 16'd1, 1'b0, 1'b0, 1'b0);
    check("priority result", final_result, 16'd2);
    drive(24'h0, 16'hFFFF, 16'h1234, 1'b1, 1'b1, 1'b1);
    check("none result", final_result, 16'h0);
    check("none mask", 16'(ccmask), 16'h0);

    @(negedge clkdbi);
    drive(24'd1 << ADD, 16'd2, 16'd3, 1'b0, 1'b0, 1'b0);
    @(posedge clkdbi); #1;
    check("reg result_q", result_q, 16'd5);
    check("reg flags_q", 16'(flags_q), 16'b0000);
    #1 reset_n = 1'b0;
    #1;
    check("async rst result_q", result_q, 16'h0);
    check("async rst flags_q", 16'(flags_q), 16'h0);
    check("comb during reset", final_result, 16'd5);
    @(negedge clkdbi) reset_n = 1'b1;

    for (int k = 0; k < 500; k++) begin
      @(negedge clkdbi);
      first = $urandom_range(0, 24);
      sv_r  = 24'h0;
      if (first < 24) begin
        sv_r[first] = 1'b1;
        if ($urandom_range(0, 3) == 0) sv_r = sv_r | (24'($urandom) << first);
      end
      drive(sv_r, pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom));
      e = model(sv_r, in1, in2, ni, ci, mbyte);
      check("rand result", final_result, e[23:8]);
      check("rand flags", 16'(final_flags), 16'(e[7:4]));
      check("rand mask", 16'(ccmask), 16'(e[3:0]));
      @(posedge clkdbi); #1;
      check("rand result_q", result_q, e[23:8]);
      check("rand flags_q", 16'(flags_q), 16'(e[7:4]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
